// File: rtl/enc8_pkg.sv
// Shared constants and code/line mapping for the 8-line request encoder family.
// Code c and line i are related by c = 7 - i, mirroring the downstream 3-to-8 decoder.
package enc8_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  localparam bit ARB_FIXED = 1'b0;
  localparam bit ARB_RR    = 1'b1;

  function automatic logic [CODE_W-1:0] line_to_code(input logic [CODE_W-1:0] i);
    return 3'd7 - i;
  endfunction

  function automatic logic [CODE_W-1:0] code_to_line(input logic [CODE_W-1:0] c);
    return 3'd7 - c;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational picker over 8 pending lines, searching in code order.
// Fixed mode starts at code 0; round-robin mode starts just after ptr and visits ptr last.
module rr_pick8
  import enc8_pkg::*;
(
  input  logic [N_LINES-1:0] pending,
  input  logic [CODE_W-1:0]  ptr,
  input  logic               mode,
  output logic               any,
  output logic [CODE_W-1:0]  code,
  output logic [N_LINES-1:0] onehot
);

  always_comb begin
    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] cand;
    any    = 1'b0;
    code   = '0;
    onehot = '0;
    // Fixed priority is round-robin with the pointer pinned at 7, so the scan starts at code 0.
    start  = (mode == ARB_RR) ? ptr : 3'd7;
    cand   = '0;
    for (int k = 1; k <= N_LINES; k++) begin
      cand = start + 3'(k);
      if (!any && pending[code_to_line(cand)]) begin
        any  = 1'b1;
        code = cand;
      end
    end
    if (any) begin
      onehot = 8'b1 << code_to_line(code);
    end
  end

endmodule

// File: rtl/req_encoder8.sv
// Sequential 8-to-3 request encoder: sticky pending set, one issued code at a time
// over a valid/ready handshake, with a merge-overflow pulse.
module req_encoder8
  import enc8_pkg::*;
#(
  parameter bit RR = ARB_FIXED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_LINES-1:0] d,
  input  logic               ready,
  output logic [CODE_W-1:0]  sel,
  output logic               valid,
  output logic [N_LINES-1:0] pending,
  output logic               busy,
  output logic               ovf
);

  logic [N_LINES-1:0] set;
  logic [N_LINES-1:0] clr;
  logic               load;
  logic [CODE_W-1:0]  ptr;
  logic               pick_any;
  logic [CODE_W-1:0]  pick_code;
  logic [N_LINES-1:0] pick_onehot;

  rr_pick8 u_pick (
    .pending (pending),
    .ptr     (ptr),
    .mode    (RR),
    .any     (pick_any),
    .code    (pick_code),
    .onehot  (pick_onehot)
  );

  always_comb begin
    set  = en ? d : '0;
    load = !valid || ready;
    clr  = (load && pick_any) ? pick_onehot : '0;
    busy = (|pending) || valid;
  end

  // New requests are OR-ed in after the clear, so a re-request of the line being issued survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | set;
      ovf     <= |(set & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      sel   <= '0;
      ptr   <= 3'd7;
    end else if (load) begin
      if (pick_any) begin
        valid <= 1'b1;
        sel   <= pick_code;
        if (RR == ARB_RR) begin
          ptr <= pick_code;
        end
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req_encoder8.sv
// Directed bench for req_encoder8: one fixed-priority and one round-robin instance
// share stimulus; each scenario task checks the instance it targets.
module tb_req_encoder8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] d = 8'h00;
  logic       ready = 1'b1;

  logic [2:0] sel_f, sel_r;
  logic       valid_f, valid_r;
  logic [7:0] pending_f, pending_r;
  logic       busy_f, busy_r;
  logic       ovf_f, ovf_r;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  req_encoder8 #(.RR(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .ready(ready),
    .sel(sel_f), .valid(valid_f), .pending(pending_f), .busy(busy_f), .ovf(ovf_f)
  );

  req_encoder8 #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .ready(ready),
    .sel(sel_r), .valid(valid_r), .pending(pending_r), .busy(busy_r), .ovf(ovf_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    d     = 8'h00;
    ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; d = 8'h00; ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (pending_f !== 8'h00) begin bad++; $display("FAIL reset_pending got=%h exp=00", pending_f); end
    total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_f); end
    total++; if (sel_f !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_f); end
    total++; if (ovf_f !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_f); end
    total++; if (busy_f !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_f); end
    rst_n = 1'b1;
    // latency: d at edge t -> pending at t -> valid after t+1
    en = 1'b1; d = 8'h80;
    tick();
    total++; if (pending_f !== 8'h80) begin bad++; $display("FAIL lat_pending got=%h exp=80", pending_f); end
    total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL lat_valid_early got=%b exp=0", valid_f); end
    en = 1'b0; d = 8'h00;
    tick();
    total++; if (valid_f !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", valid_f); end
    total++; if (sel_f !== 3'd0) begin bad++; $display("FAIL lat_sel got=%0d exp=0", sel_f); end
    total++; if (pending_f !== 8'h00) begin bad++; $display("FAIL lat_pending_clr got=%h exp=00", pending_f); end
    tick();
    total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL lat_valid_drop got=%b exp=0", valid_f); end
    total++; if (busy_f !== 1'b0) begin bad++; $display("FAIL lat_busy got=%b exp=0", busy_f); end
  endtask

  task automatic test_fixed_drain();
    logic [2:0] exp_sel [3];
    logic [7:0] exp_pend [3];
    exp_sel  = '{3'd2, 3'd5, 3'd7};
    exp_pend = '{8'h05, 8'h01, 8'h00};
    do_reset();
    en = 1'b1; d = 8'h25; ready = 1'b1;
    tick();
    en = 1'b0; d = 8'h00;
    total++; if (pending_f !== 8'h25) begin bad++; $display("FAIL drain_capture got=%h exp=25", pending_f); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (valid_f !== 1'b1 || sel_f !== exp_sel[i]) begin
        bad++; $display("FAIL drain_sel[%0d] got=%0d/v%b exp=%0d/v1", i, sel_f, valid_f, exp_sel[i]);
      end
      total++; if (pending_f !== exp_pend[i]) begin
        bad++; $display("FAIL drain_pend[%0d] got=%h exp=%h", i, pending_f, exp_pend[i]);
      end
    end
    tick();
    total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL drain_end_valid got=%b exp=0", valid_f); end
    total++; if (busy_f !== 1'b0) begin bad++; $display("FAIL drain_end_busy got=%b exp=0", busy_f); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel [4];
    exp_sel = '{3'd0, 3'd3, 3'd0, 3'd3};
    do_reset();
    en = 1'b1; d = 8'h90; ready = 1'b1;
    tick();
    total++; if (pending_r !== 8'h90 || valid_r !== 1'b0 || ovf_r !== 1'b0) begin
      bad++; $display("FAIL rr_capture got=%h/v%b/o%b exp=90/v0/o0", pending_r, valid_r, ovf_r);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (valid_r !== 1'b1 || sel_r !== exp_sel[i]) begin
        bad++; $display("FAIL rr_sel[%0d] got=%0d/v%b exp=%0d/v1", i, sel_r, valid_r, exp_sel[i]);
      end
      total++; if (ovf_r !== 1'b1) begin bad++; $display("FAIL rr_ovf[%0d] got=%b exp=1", i, ovf_r); end
      total++; if (pending_r !== 8'h90) begin bad++; $display("FAIL rr_pend[%0d] got=%h exp=90", i, pending_r); end
    end
    en = 1'b0; d = 8'h00;
    tick();
    total++; if (sel_r !== 3'd0 || ovf_r !== 1'b0 || pending_r !== 8'h10) begin
      bad++; $display("FAIL rr_tail0 got=%0d/o%b/%h exp=0/o0/10", sel_r, ovf_r, pending_r);
    end
    tick();
    total++; if (sel_r !== 3'd3 || valid_r !== 1'b1 || pending_r !== 8'h00) begin
      bad++; $display("FAIL rr_tail1 got=%0d/v%b/%h exp=3/v1/00", sel_r, valid_r, pending_r);
    end
    tick();
    total++; if (valid_r !== 1'b0 || busy_r !== 1'b0) begin
      bad++; $display("FAIL rr_idle got=v%b/b%b exp=v0/b0", valid_r, busy_r);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0; en = 1'b1; d = 8'h03;
    tick();
    en = 1'b0; d = 8'h00;
    total++; if (pending_f !== 8'h03) begin bad++; $display("FAIL bp_capture got=%h exp=03", pending_f); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (sel_f !== 3'd6 || valid_f !== 1'b1 || pending_f !== 8'h01) begin
        bad++; $display("FAIL bp_hold[%0d] got=%0d/v%b/%h exp=6/v1/01", i, sel_f, valid_f, pending_f);
      end
    end
    ready = 1'b1;
    tick();
    total++; if (sel_f !== 3'd7 || valid_f !== 1'b1 || pending_f !== 8'h00) begin
      bad++; $display("FAIL bp_next got=%0d/v%b/%h exp=7/v1/00", sel_f, valid_f, pending_f);
    end
    tick();
    total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL bp_done got=%b exp=0", valid_f); end
  endtask

  task automatic test_set_over_clear();
    do_reset();
    en = 1'b1; d = 8'h40; ready = 1'b1;
    tick();
    // same line requested again on the cycle it is loaded
    tick();
    total++; if (sel_f !== 3'd1 || valid_f !== 1'b1) begin
      bad++; $display("FAIL soc_first got=%0d/v%b exp=1/v1", sel_f, valid_f);
    end
    total++; if (pending_f !== 8'h40) begin bad++; $display("FAIL soc_keep got=%h exp=40", pending_f); end
    total++; if (ovf_f !== 1'b0) begin bad++; $display("FAIL soc_ovf got=%b exp=0", ovf_f); end
    en = 1'b0; d = 8'h00;
    tick();
    total++; if (sel_f !== 3'd1 || valid_f !== 1'b1 || pending_f !== 8'h00) begin
      bad++; $display("FAIL soc_second got=%0d/v%b/%h exp=1/v1/00", sel_f, valid_f, pending_f);
    end
    tick();
    total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL soc_idle got=%b exp=0", valid_f); end
    en = 1'b0; d = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (pending_f !== 8'h00 || valid_f !== 1'b0 || ovf_f !== 1'b0 || busy_f !== 1'b0) begin
        bad++; $display("FAIL en_gate[%0d] got=%h/v%b/o%b/b%b exp=00/v0/o0/b0", i, pending_f, valid_f, ovf_f, busy_f);
      end
    end
    d = 8'h00;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; d = 8'h08; ready = 1'b0;
    tick();
    d = 8'hF0;
    tick();
    en = 1'b0; d = 8'h00;
    total++; if (pending_f !== 8'hF0 || valid_f !== 1'b1 || sel_f !== 3'd4) begin
      bad++; $display("FAIL ar_setup got=%h/v%b/%0d exp=F0/v1/4", pending_f, valid_f, sel_f);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (pending_f !== 8'h00 || valid_f !== 1'b0 || sel_f !== 3'd0 || busy_f !== 1'b0) begin
      bad++; $display("FAIL ar_immediate got=%h/v%b/%0d/b%b exp=00/v0/0/b0", pending_f, valid_f, sel_f, busy_f);
    end
    #2;
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (valid_f !== 1'b0 || pending_f !== 8'h00) begin
        bad++; $display("FAIL ar_quiet[%0d] got=v%b/%h exp=v0/00", i, valid_f, pending_f);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_fixed_drain();
    test_round_robin();
    test_backpressure();
    test_set_over_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
